id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline stage feeding the ALU operand inputs (A, B, AlUControlInput).
//  - Registers decoded operands and controls; resolves EX/MEM and MEM/WB data forwarding.
//  - Detects load-use hazards and inserts bubbles.
//  - Uses valid/ready handshakes toward decode (upstream) and the EX/MEM stage (downstream).
// PARAMETERS
//  DATA_W      32  datapath width
//  REG_ADDR_W  5   register specifier width
//  CTRL_W      4   ALU control code width
// PORTS
//  clk              in   1          single clock, rising edge
//  reset            in   1          synchronous, active-high
//  Flush            in   1          sync kill of held and incoming instruction (branch/jump redirect)
//  InValid          in   1          decode presents an instruction
//  InReady          out  1          stage accepts this cycle
//  RegData1         in   DATA_W     register-file read of Rs
//  RegData2         in   DATA_W     register-file read of Rt
//  Imm              in   DATA_W     sign/zero-extended immediate
//  Shamt            in   5          shift amount field
//  Rs               in   REG_ADDR_W source specifier 1
//  Rt               in   REG_ADDR_W source specifier 2
//  DestReg          in   REG_ADDR_W resolved destination register (Rd or Rt)
//  ALUCtrlIn        in   CTRL_W     ALU operation code from ALU control decoder
//  ALUSrc           in   1          1: B = Imm
//  ShiftSrc         in   1          1: A = zero-extended Shamt
//  RegWriteIn       in   1          control passthrough
//  MemReadIn        in   1          control passthrough
//  MemWriteIn       in   1          control passthrough
//  MemToRegIn       in   1          control passthrough
//  ExMemRegWrite    in   1          EX/MEM writes a register
//  ExMemRd          in   REG_ADDR_W EX/MEM destination
//  ExMemResult      in   DATA_W     EX/MEM ALU result
//  MemWbRegWrite    in   1          MEM/WB writes a register
//  MemWbRd          in   REG_ADDR_W MEM/WB destination
//  MemWbData        in   DATA_W     MEM/WB writeback value
//  OutValid         out  1          A/B/controls valid for the ALU this cycle
//  OutReady         in   1          EX/MEM accepts this cycle
//  A                out  DATA_W     ALU operand A
//  B                out  DATA_W     ALU operand B
//  AlUControlInput  out  CTRL_W     ALU operation code
//  StoreData        out  DATA_W     forwarded Rt value for stores
//  WriteReg         out  REG_ADDR_W registered DestReg
//  RegWrite, MemRead, MemWrite, MemToReg  out  1  registered controls, qualified by OutValid
//  LoadUseStall     out  1          hazard indicator (debug/perf)
// BEHAVIOUR
//  - Reset: OutValid=0; all held registers 0; A=B=StoreData=0; AlUControlInput=0;
//    WriteReg=0; all controls 0. Reset mid-transfer discards the held instruction.
//  - Single entry, latency 1: instruction accepted at edge N drives the ALU in cycle N+1.
//  - Handshake: InReady = (!OutValid || OutReady) && !LoadUseStall.
//    Capture when InValid && InReady. If the entry leaves with no capture, OutValid goes 0.
//    OutValid && !OutReady holds all outputs stable except forwarding refresh (below).
//  - Load-use hazard: LoadUseStall = OutValid && MemRead && RegWrite && WriteReg!=0 &&
//    InValid && (WriteReg==Rs || WriteReg==Rt).
//    Under LoadUseStall with OutReady=1, the load leaves and a bubble loads (OutValid=0).
//  - Forwarding (sub-module fwd_mux), per source, priority:
//    EX/MEM hit > MEM/WB hit > stored value.
//    Hit = RegWrite && Rd==src && src!=0. Register 0 is never forwarded.
//  - Refresh: MEM/WB hits are also applied to RegData at capture, and to the stored operands
//    every held cycle, so values retiring during a stall are not lost.
//  - Operand select after forwarding: A = ShiftSrc ? {27'b0,Shamt} : fwdRs;
//    B = ALUSrc ? Imm : fwdRt; StoreData = fwdRt.
//  - Flush: next edge OutValid=0 and no capture, even if InValid. Priority: reset > Flush > capture.
//  - All arithmetic is width-preserving; no sign handling occurs in this block.
// STRUCTURE
//  - mips_defs.vh holds ALU codes (ADD 0111, SUB 0100, AND 0110, OR 0101, XOR 0000,
//    SLL 0001, SRL 0010, NOR 0011, SLT 1000), DATA_W and REG_ADDR_W.
//  - Sub-module fwd_mux: one instance per source operand. It is combinational and
//    takes (src, stored, ExMem*, MemWb*) and returns the forwarded value.
// TESTING
//  1. Reset high 2 cycles with InValid=1 -> OutValid=0, A=B=0, InReady=1 after release.
//  2. ADD: RegData1=5, RegData2=7, ALUCtrlIn=0111, ALUSrc=0 -> next cycle A=5, B=7,
//     AlUControlInput=0111, OutValid=1.
//  3. Forwarding: Rs=3, ExMemRd=3 (0x10) and MemWbRd=3 (0x20) -> A=0x10; with ExMemRegWrite=0,
//     A=0x20; with Rs=0, A=RegData1.
//  4. Load-use: held lw to $8, incoming Rs=8 -> LoadUseStall=1, InReady=0, bubble for 1 cycle,
//     then capture.
//  5. Backpressure: OutReady=0 for 3 cycles, MemWb writes held Rt=9 (0xAB) in cycle 2 -> B=0xAB,
//     other outputs stable.
//  6. Flush with InValid=1 and a held entry -> next cycle OutValid=0; SLL (ShiftSrc=1, Shamt=4)
//     afterwards -> A=4.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU operation codes and the forwarding hit rule for the ID/EX stage.
package id_ex_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 4;
  localparam int SHAMT_W    = 5;

  typedef enum logic [CTRL_W-1:0] {
    ALU_XOR = 4'b0000,
    ALU_SLL = 4'b0001,
    ALU_SRL = 4'b0010,
    ALU_NOR = 4'b0011,
    ALU_SUB = 4'b0100,
    ALU_OR  = 4'b0101,
    ALU_AND = 4'b0110,
    ALU_ADD = 4'b0111,
    ALU_SLT = 4'b1000
  } alu_op_e;

  // Register 0 is hardwired to zero, so a write to it must never be forwarded.
  function automatic logic fwd_hit(input logic                  we,
                                   input logic [REG_ADDR_W-1:0] rd,
                                   input logic [REG_ADDR_W-1:0] src);
    return we && (rd == src) && (src != {REG_ADDR_W{1'b0}});
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Combinational operand forwarding: EX/MEM result beats MEM/WB data beats the stored value.
module fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_src,
  input  logic [DATA_W-1:0]     i_stored,
  input  logic                  i_ex_we,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic [DATA_W-1:0]     i_ex_data,
  input  logic                  i_wb_we,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic [DATA_W-1:0]     i_wb_data,
  output logic [DATA_W-1:0]     o_fwd
);

  // Priority select between the two bypass sources and the held operand.
  always_comb begin
    o_fwd = i_stored;
    if (fwd_hit(i_ex_we, i_ex_rd, i_src)) begin
      o_fwd = i_ex_data;
    end else if (fwd_hit(i_wb_we, i_wb_rd, i_src)) begin
      o_fwd = i_wb_data;
    end else begin
      o_fwd = i_stored;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble insertion and
// valid/ready handshakes toward decode and EX/MEM.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Flush,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [DATA_W-1:0]     RegData1,
  input  logic [DATA_W-1:0]     RegData2,
  input  logic [DATA_W-1:0]     Imm,
  input  logic [SHAMT_W-1:0]    Shamt,
  input  logic [REG_ADDR_W-1:0] Rs,
  input  logic [REG_ADDR_W-1:0] Rt,
  input  logic [REG_ADDR_W-1:0] DestReg,
  input  logic [CTRL_W-1:0]     ALUCtrlIn,
  input  logic                  ALUSrc,
  input  logic                  ShiftSrc,
  input  logic                  RegWriteIn,
  input  logic                  MemReadIn,
  input  logic                  MemWriteIn,
  input  logic                  MemToRegIn,
  input  logic                  ExMemRegWrite,
  input  logic [REG_ADDR_W-1:0] ExMemRd,
  input  logic [DATA_W-1:0]     ExMemResult,
  input  logic                  MemWbRegWrite,
  input  logic [REG_ADDR_W-1:0] MemWbRd,
  input  logic [DATA_W-1:0]     MemWbData,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DATA_W-1:0]     A,
  output logic [DATA_W-1:0]     B,
  output logic [CTRL_W-1:0]     AlUControlInput,
  output logic [DATA_W-1:0]     StoreData,
  output logic [REG_ADDR_W-1:0] WriteReg,
  output logic                  RegWrite,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  MemToReg,
  output logic                  LoadUseStall
);

  logic                  r_valid;
  logic [REG_ADDR_W-1:0] r_rs;
  logic [REG_ADDR_W-1:0] r_rt;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [CTRL_W-1:0]     r_ctrl;
  logic                  r_alusrc;
  logic                  r_shiftsrc;
  logic                  r_regwrite;
  logic                  r_memread;
  logic                  r_memwrite;
  logic                  r_memtoreg;
  logic [DATA_W-1:0]     r_data1;
  logic [DATA_W-1:0]     r_data2;
  logic [DATA_W-1:0]     r_imm;
  logic [SHAMT_W-1:0]    r_shamt;

  logic                  w_stall;
  logic                  w_in_ready;
  logic                  w_capture;
  logic [DATA_W-1:0]     w_cap_data1;
  logic [DATA_W-1:0]     w_cap_data2;
  logic [DATA_W-1:0]     w_ref_data1;
  logic [DATA_W-1:0]     w_ref_data2;
  logic [DATA_W-1:0]     w_fwd_rs;
  logic [DATA_W-1:0]     w_fwd_rt;

  // A held load whose target is read by the incoming instruction cannot be bypassed in time.
  assign w_stall = r_valid && r_memread && r_regwrite && (r_rd != {REG_ADDR_W{1'b0}}) &&
                   InValid && ((r_rd == Rs) || (r_rd == Rt));
  assign w_in_ready = (!r_valid || OutReady) && !w_stall;
  assign w_capture  = InValid && w_in_ready && !Flush;

  // The register file may be written this very cycle, so MEM/WB patches both fresh and held operands.
  assign w_cap_data1 = fwd_hit(MemWbRegWrite, MemWbRd, Rs)   ? MemWbData : RegData1;
  assign w_cap_data2 = fwd_hit(MemWbRegWrite, MemWbRd, Rt)   ? MemWbData : RegData2;
  assign w_ref_data1 = fwd_hit(MemWbRegWrite, MemWbRd, r_rs) ? MemWbData : r_data1;
  assign w_ref_data2 = fwd_hit(MemWbRegWrite, MemWbRd, r_rt) ? MemWbData : r_data2;

  // Pipeline register: reset beats flush, flush beats capture; unaccepted entries drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_rs       <= {REG_ADDR_W{1'b0}};
      r_rt       <= {REG_ADDR_W{1'b0}};
      r_rd       <= {REG_ADDR_W{1'b0}};
      r_ctrl     <= {CTRL_W{1'b0}};
      r_alusrc   <= 1'b0;
      r_shiftsrc <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_data1    <= {DATA_W{1'b0}};
      r_data2    <= {DATA_W{1'b0}};
      r_imm      <= {DATA_W{1'b0}};
      r_shamt    <= {SHAMT_W{1'b0}};
    end else begin
      if (Flush) begin
        r_valid <= 1'b0;
      end else if (w_capture) begin
        r_valid <= 1'b1;
      end else if (OutReady) begin
        r_valid <= 1'b0;
      end
      if (w_capture) begin
        r_rs       <= Rs;
        r_rt       <= Rt;
        r_rd       <= DestReg;
        r_ctrl     <= ALUCtrlIn;
        r_alusrc   <= ALUSrc;
        r_shiftsrc <= ShiftSrc;
        r_regwrite <= RegWriteIn;
        r_memread  <= MemReadIn;
        r_memwrite <= MemWriteIn;
        r_memtoreg <= MemToRegIn;
        r_data1    <= w_cap_data1;
        r_data2    <= w_cap_data2;
        r_imm      <= Imm;
        r_shamt    <= Shamt;
      end else begin
        r_data1    <= w_ref_data1;
        r_data2    <= w_ref_data2;
      end
    end
  end

  fwd_mux u_fwd_rs (
    .i_src     (r_rs),
    .i_stored  (r_data1),
    .i_ex_we   (ExMemRegWrite),
    .i_ex_rd   (ExMemRd),
    .i_ex_data (ExMemResult),
    .i_wb_we   (MemWbRegWrite),
    .i_wb_rd   (MemWbRd),
    .i_wb_data (MemWbData),
    .o_fwd     (w_fwd_rs)
  );

  fwd_mux u_fwd_rt (
    .i_src     (r_rt),
    .i_stored  (r_data2),
    .i_ex_we   (ExMemRegWrite),
    .i_ex_rd   (ExMemRd),
    .i_ex_data (ExMemResult),
    .i_wb_we   (MemWbRegWrite),
    .i_wb_rd   (MemWbRd),
    .i_wb_data (MemWbData),
    .o_fwd     (w_fwd_rt)
  );

  assign InReady         = w_in_ready;
  assign LoadUseStall    = w_stall;
  assign OutValid        = r_valid;
  assign A               = r_shiftsrc ? {{(DATA_W-SHAMT_W){1'b0}}, r_shamt} : w_fwd_rs;
  assign B               = r_alusrc ? r_imm : w_fwd_rt;
  assign StoreData       = w_fwd_rt;
  assign AlUControlInput = r_ctrl;
  assign WriteReg        = r_rd;
  assign RegWrite        = r_valid && r_regwrite;
  assign MemRead         = r_valid && r_memread;
  assign MemWrite        = r_valid && r_memwrite;
  assign MemToReg        = r_valid && r_memtoreg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized bench for id_ex_stage against a one-entry instruction model.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset, Flush, InValid, InReady;
  logic [31:0] RegData1, RegData2, Imm;
  logic [4:0]  Shamt, Rs, Rt, DestReg;
  logic [3:0]  ALUCtrlIn;
  logic        ALUSrc, ShiftSrc, RegWriteIn, MemReadIn, MemWriteIn, MemToRegIn;
  logic        ExMemRegWrite, MemWbRegWrite;
  logic [4:0]  ExMemRd, MemWbRd;
  logic [31:0] ExMemResult, MemWbData;
  logic        OutValid, OutReady;
  logic [31:0] A, B, StoreData;
  logic [3:0]  AlUControlInput;
  logic [4:0]  WriteReg;
  logic        RegWrite, MemRead, MemWrite, MemToReg, LoadUseStall;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [4:0]  rs, rt, rd, shamt;
    logic [3:0]  ctrl;
    logic        alusrc, shiftsrc, rw, mr, mw, m2r;
    logic [31:0] v1, v2, imm;
  } ins_t;

  ins_t m;
  bit   m_valid;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .RegData1(RegData1), .RegData2(RegData2), .Imm(Imm), .Shamt(Shamt),
    .Rs(Rs), .Rt(Rt), .DestReg(DestReg), .ALUCtrlIn(ALUCtrlIn),
    .ALUSrc(ALUSrc), .ShiftSrc(ShiftSrc), .RegWriteIn(RegWriteIn),
    .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn), .MemToRegIn(MemToRegIn),
    .ExMemRegWrite(ExMemRegWrite), .ExMemRd(ExMemRd), .ExMemResult(ExMemResult),
    .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd), .MemWbData(MemWbData),
    .OutValid(OutValid), .OutReady(OutReady), .A(A), .B(B),
    .AlUControlInput(AlUControlInput), .StoreData(StoreData), .WriteReg(WriteReg),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .LoadUseStall(LoadUseStall)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Value the ALU should see for a source register, given what was stored for it.
  function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] stored);
    if (src != 5'd0 && ExMemRegWrite && ExMemRd == src) return ExMemResult;
    if (src != 5'd0 && MemWbRegWrite && MemWbRd == src) return MemWbData;
    return stored;
  endfunction

  function automatic logic [31:0] wb_only(input logic [4:0] src, input logic [31:0] val);
    if (src != 5'd0 && MemWbRegWrite && MemWbRd == src) return MemWbData;
    return val;
  endfunction

  function automatic logic exp_stall();
    return m_valid && m.mr && m.rw && m.rd != 5'd0 && InValid && (m.rd == Rs || m.rd == Rt);
  endfunction

  function automatic logic exp_ready();
    return (!m_valid || OutReady) && !exp_stall();
  endfunction

  task automatic check_all();
    chk1("OutValid", OutValid, m_valid);
    chk1("InReady", InReady, exp_ready());
    chk1("LoadUseStall", LoadUseStall, exp_stall());
    chk1("RegWrite", RegWrite, m_valid && m.rw);
    chk1("MemRead", MemRead, m_valid && m.mr);
    chk1("MemWrite", MemWrite, m_valid && m.mw);
    chk1("MemToReg", MemToReg, m_valid && m.m2r);
    if (m_valid) begin
      chk32("A", A, m.shiftsrc ? {27'd0, m.shamt} : ref_fwd(m.rs, m.v1));
      chk32("B", B, m.alusrc ? m.imm : ref_fwd(m.rt, m.v2));
      chk32("StoreData", StoreData, ref_fwd(m.rt, m.v2));
      chk32("AluCtrl", {28'd0, AlUControlInput}, {28'd0, m.ctrl});
      chk32("WriteReg", {27'd0, WriteReg}, {27'd0, m.rd});
    end
  endtask

  task automatic model_update();
    logic cap;
    if (reset) begin
      m_valid = 1'b0;
      m = '0;
    end else begin
      cap = InValid && exp_ready() && !Flush;
      if (cap) begin
        m.rs = Rs; m.rt = Rt; m.rd = DestReg; m.shamt = Shamt; m.ctrl = ALUCtrlIn;
        m.alusrc = ALUSrc; m.shiftsrc = ShiftSrc; m.rw = RegWriteIn; m.mr = MemReadIn;
        m.mw = MemWriteIn; m.m2r = MemToRegIn; m.imm = Imm;
        m.v1 = wb_only(Rs, RegData1);
        m.v2 = wb_only(Rt, RegData2);
      end else begin
        m.v1 = wb_only(m.rs, m.v1);
        m.v2 = wb_only(m.rt, m.v2);
      end
      if (Flush) m_valid = 1'b0;
      else if (cap) m_valid = 1'b1;
      else if (OutReady) m_valid = 1'b0;
    end
  endtask

  // Inputs are set shortly after a rising edge; checks and the model step precede the next edge.
  task automatic cycle();
    #1;
    if (!reset) check_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    RegData1 = 32'd0; RegData2 = 32'd0; Imm = 32'd0; Shamt = 5'd0;
    Rs = 5'd0; Rt = 5'd0; DestReg = 5'd0; ALUCtrlIn = 4'd0;
    ALUSrc = 1'b0; ShiftSrc = 1'b0; RegWriteIn = 1'b0; MemReadIn = 1'b0;
    MemWriteIn = 1'b0; MemToRegIn = 1'b0;
    ExMemRegWrite = 1'b0; ExMemRd = 5'd0; ExMemResult = 32'd0;
    MemWbRegWrite = 1'b0; MemWbRd = 5'd0; MemWbData = 32'd0;
  endtask

  task automatic rand_inputs();
    reset = ($urandom_range(0, 63) == 0);
    Flush = ($urandom_range(0, 15) == 0);
    InValid = ($urandom_range(0, 3) != 0);
    OutReady = ($urandom_range(0, 3) != 0);
    RegData1 = $urandom; RegData2 = $urandom; Imm = $urandom;
    Shamt = 5'($urandom_range(0, 31));
    Rs = 5'($urandom_range(0, 3)); Rt = 5'($urandom_range(0, 3));
    DestReg = 5'($urandom_range(0, 3));
    ALUCtrlIn = 4'($urandom_range(0, 8));
    ALUSrc = 1'($urandom_range(0, 1)); ShiftSrc = 1'($urandom_range(0, 1));
    RegWriteIn = 1'($urandom_range(0, 1)); MemReadIn = 1'($urandom_range(0, 1));
    MemWriteIn = 1'($urandom_range(0, 1)); MemToRegIn = 1'($urandom_range(0, 1));
    ExMemRegWrite = 1'($urandom_range(0, 1)); ExMemRd = 5'($urandom_range(0, 3));
    ExMemResult = $urandom;
    MemWbRegWrite = 1'($urandom_range(0, 1)); MemWbRd = 5'($urandom_range(0, 3));
    MemWbData = $urandom;
  endtask

  initial begin
    m = '0;
    m_valid = 1'b0;
    idle();
    // Reset held two cycles while decode offers an instruction.
    reset = 1'b1; InValid = 1'b1; RegData1 = 32'h1234; RegData2 = 32'h5678; Rs = 5'd1;
    @(posedge clk); #1;
    cycle();
    cycle();
    idle(); #1;
    chk1("rst_OutValid", OutValid, 1'b0);
    chk32("rst_A", A, 32'd0);
    chk32("rst_B", B, 32'd0);
    chk1("rst_InReady", InReady, 1'b1);
    cycle();

    // ADD with register operands.
    idle(); InValid = 1'b1; RegData1 = 32'd5; RegData2 = 32'd7; Rs = 5'd1; Rt = 5'd2;
    DestReg = 5'd3; ALUCtrlIn = ALU_ADD; RegWriteIn = 1'b1;
    cycle();
    idle(); #1;
    chk32("add_A", A, 32'd5);
    chk32("add_B", B, 32'd7);
    chk32("add_ctrl", {28'd0, AlUControlInput}, 32'h7);
    chk1("add_valid", OutValid, 1'b1);
    cycle();

    // Forwarding priority and register-0 exclusion.
    idle(); InValid = 1'b1; Rs = 5'd3; RegData1 = 32'h99;
    cycle();
    idle(); OutReady = 1'b0;
    ExMemRegWrite = 1'b1; ExMemRd = 5'd3; ExMemResult = 32'h10;
    MemWbRegWrite = 1'b1; MemWbRd = 5'd3; MemWbData = 32'h20; #1;
    chk32("fwd_exmem", A, 32'h10);
    cycle();
    idle(); OutReady = 1'b0; MemWbRegWrite = 1'b1; MemWbRd = 5'd3; MemWbData = 32'h20; #1;
    chk32("fwd_memwb", A, 32'h20);
    cycle();
    idle(); InValid = 1'b1; Rs = 5'd0; RegData1 = 32'h55;
    ExMemRegWrite = 1'b1; MemWbRegWrite = 1'b1; MemWbData = 32'h66;
    cycle();
    idle(); ExMemRegWrite = 1'b1; ExMemResult = 32'h77; #1;
    chk32("fwd_r0", A, 32'h55);
    cycle();

    // Load-use bubble.
    idle(); InValid = 1'b1; MemReadIn = 1'b1; RegWriteIn = 1'b1; MemToRegIn = 1'b1;
    DestReg = 5'd8; Rs = 5'd4; Rt = 5'd5;
    cycle();
    idle(); InValid = 1'b1; Rs = 5'd8; Rt = 5'd6; RegData1 = 32'h123; #1;
    chk1("lu_stall", LoadUseStall, 1'b1);
    chk1("lu_inready", InReady, 1'b0);
    cycle();
    #1;
    chk1("lu_bubble", OutValid, 1'b0);
    chk1("lu_ready_again", InReady, 1'b1);
    cycle();
    idle(); #1;
    chk1("lu_captured", OutValid, 1'b1);
    chk32("lu_A", A, 32'h123);
    cycle();

    // Backpressure with a MEM/WB write to the held Rt mid-stall.
    idle(); InValid = 1'b1; Rt = 5'd9; RegData2 = 32'h11; ALUCtrlIn = ALU_SUB;
    DestReg = 5'd10; RegWriteIn = 1'b1;
    cycle();
    idle(); OutReady = 1'b0; #1;
    chk32("bp_B1", B, 32'h11);
    cycle();
    idle(); OutReady = 1'b0; MemWbRegWrite = 1'b1; MemWbRd = 5'd9; MemWbData = 32'hAB; #1;
    chk32("bp_B2", B, 32'hAB);
    cycle();
    idle(); OutReady = 1'b0; #1;
    chk32("bp_B3", B, 32'hAB);
    chk32("bp_ctrl", {28'd0, AlUControlInput}, 32'h4);
    chk32("bp_wreg", {27'd0, WriteReg}, 32'd10);
    chk1("bp_valid", OutValid, 1'b1);
    cycle();

    // Flush kills held and incoming, then a shift captures.
    idle(); InValid = 1'b1; DestReg = 5'd11; RegWriteIn = 1'b1;
    cycle();
    idle(); OutReady = 1'b0; InValid = 1'b1; Flush = 1'b1; RegData1 = 32'h999;
    cycle();
    idle(); #1;
    chk1("flush_valid", OutValid, 1'b0);
    InValid = 1'b1; ShiftSrc = 1'b1; Shamt = 5'd4; ALUCtrlIn = ALU_SLL;
    Rs = 5'd2; RegData1 = 32'hFFFF;
    cycle();
    idle(); #1;
    chk32("sll_A", A, 32'd4);
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
